andar_fusao: RTL and testbench

Parametrised floor-position detector for the SmartCargo elevator. It fuses N active-low floor-limit sensors with an external ultrasonic distance measurement. Sensors are synchronised and debounced. When no sensor is active, the block periodically requests ultrasonic measurements and converts each distance to a floor index. It publishes a held floor value with source, validity, change and error flags to the elevator controller and the display path.

---
 rtl/smartcargo_pkg.sv | 16 +
 rtl/andar_fusao_debounce_sensores.sv | 45 ++++
 rtl/andar_fusao.sv | 212 +++++++++++++++++++++
 tb/tb_andar_fusao.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smartcargo_pkg.sv
// Shared types and constants for the SmartCargo floor-position logic.
package smartcargo_pkg;

   // States of the ultrasonic measurement sequencer
   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESPERA   = 2'd1,
      MEDE     = 2'd2,
      CONVERTE = 2'd3
   } estado_us_t;

   // Source tag published alongside the floor value
   localparam logic FONTE_SENSOR = 1'b0;
   localparam logic FONTE_US     = 1'b1;

endpackage

// File: rtl/andar_fusao_debounce_sensores.sv
// Synchronises the asynchronous floor-limit sensors and accepts a pattern
// only after it has stayed unchanged for CICLOS consecutive cycles.
module debounce_sensores #(
   parameter int LARGURA = 4,
   parameter int CICLOS  = 50000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] sensores,
   output logic [LARGURA-1:0] padrao,
   output logic               aceito
);

   localparam int W_CNT = $clog2(CICLOS) + 1;
   localparam logic [W_CNT-1:0] LIMITE = W_CNT'(CICLOS - 1);

   logic [LARGURA-1:0] sinc1;
   logic [LARGURA-1:0] sinc2;
   logic [LARGURA-1:0] referencia;
   logic [W_CNT-1:0]   cnt_estavel;

   // Two-flop synchroniser followed by a stability counter that restarts on any pattern change
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sinc1       <= '1;
         sinc2       <= '1;
         referencia  <= '1;
         cnt_estavel <= '0;
      end else begin
         sinc1      <= sensores;
         sinc2      <= sinc1;
         referencia <= sinc2;
         if (sinc2 != referencia) begin
            cnt_estavel <= '0;
         end else if (cnt_estavel != LIMITE) begin
            cnt_estavel <= cnt_estavel + W_CNT'(1);
         end
      end
   end

   // The strobe stays high every cycle while the pattern remains stable
   assign aceito = (sinc2 == referencia) && (cnt_estavel == LIMITE);
   assign padrao = referencia;

endmodule

// File: rtl/andar_fusao.sv
// Floor-position detector: fuses debounced limit sensors with periodic
// ultrasonic distance readings and publishes a held floor value.
module andar_fusao
   import smartcargo_pkg::*;
#(
   parameter int N_ANDARES       = 4,
   parameter int W_ANDAR         = $clog2(N_ANDARES),
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int PERIODO_MEDIDA  = 5000000,
   parameter int TIMEOUT_CICLOS  = 2500000,
   parameter int ALTURA_CM       = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_ANDARES-1:0] sensores,
   input  logic [11:0]          distancia_cm,
   input  logic                 distancia_valida,
   output logic                 medir,
   output logic [W_ANDAR-1:0]   andar,
   output logic                 andar_valido,
   output logic                 fonte,
   output logic                 mudou,
   output logic                 erro_sensor,
   output logic                 erro_us
);

   localparam int W_CONT = $clog2(N_ANDARES + 1);
   localparam int W_PER  = $clog2(PERIODO_MEDIDA + 1);
   localparam int W_TO   = $clog2(TIMEOUT_CICLOS + 1);
   localparam int W_Q    = W_ANDAR + 1;

   localparam logic [12:0]      ALTURA = 13'(ALTURA_CM);
   localparam logic [12:0]      MEIA   = 13'(ALTURA_CM / 2);
   localparam logic [W_Q-1:0]   Q_MAX  = W_Q'(N_ANDARES - 1);

   logic [N_ANDARES-1:0] padrao;
   logic                 aceito;

   logic [W_CONT-1:0]    n_baixos;
   logic [W_ANDAR-1:0]   idx_baixo;
   logic                 sensor_unico;
   logic                 sensor_multiplo;
   logic                 sensor_livre;
   logic                 forca_ocioso;
   logic                 us_habilitado;

   estado_us_t           estado;
   estado_us_t           estado_prox;
   logic                 pulso_medir;
   logic                 ev_timeout;
   logic                 ev_conv_ok;
   logic                 ev_conv_fora;

   logic [W_PER-1:0]     cnt_periodo;
   logic [W_TO-1:0]      cnt_timeout;
   logic [12:0]          acumulador;
   logic [W_Q-1:0]       quociente;

   debounce_sensores #(
      .LARGURA (N_ANDARES),
      .CICLOS  (DEBOUNCE_CICLOS)
   ) u_debounce (
      .clock    (clock),
      .reset    (reset),
      .sensores (sensores),
      .padrao   (padrao),
      .aceito   (aceito)
   );

   // Count the active (low) sensors and remember which one is low
   always_comb begin
      n_baixos  = '0;
      idx_baixo = '0;
      for (int k = 0; k < N_ANDARES; k++) begin
         if (!padrao[k]) begin
            n_baixos  = n_baixos + W_CONT'(1);
            idx_baixo = W_ANDAR'(k);
         end
      end
   end

   assign sensor_unico    = aceito && (n_baixos == W_CONT'(1));
   assign sensor_multiplo = aceito && (n_baixos >  W_CONT'(1));
   assign sensor_livre    = aceito && (n_baixos == '0);
   assign forca_ocioso    = sensor_unico || sensor_multiplo;

   // Next-state logic of the ultrasonic sequencer; any sensor hit sends it back to idle
   always_comb begin
      estado_prox  = estado;
      pulso_medir  = 1'b0;
      ev_timeout   = 1'b0;
      ev_conv_ok   = 1'b0;
      ev_conv_fora = 1'b0;
      if (forca_ocioso) begin
         estado_prox = OCIOSO;
      end else begin
         case (estado)
            OCIOSO: begin
               if (us_habilitado) estado_prox = ESPERA;
            end
            ESPERA: begin
               if (cnt_periodo <= W_PER'(1)) begin
                  estado_prox = MEDE;
                  pulso_medir = 1'b1;
               end
            end
            MEDE: begin
               if (distancia_valida) begin
                  estado_prox = CONVERTE;
               end else if (cnt_timeout <= W_TO'(1)) begin
                  estado_prox = ESPERA;
                  ev_timeout  = 1'b1;
               end
            end
            CONVERTE: begin
               if (acumulador < ALTURA) begin
                  estado_prox = ESPERA;
                  ev_conv_ok  = 1'b1;
               end else if (quociente == Q_MAX) begin
                  estado_prox  = ESPERA;
                  ev_conv_fora = 1'b1;
               end
            end
            default: estado_prox = OCIOSO;
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= estado_prox;
      end
   end

   // Period and timeout counters, plus the repeated-subtraction divider
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         us_habilitado <= 1'b0;
         cnt_periodo   <= '0;
         cnt_timeout   <= '0;
         acumulador    <= '0;
         quociente     <= '0;
      end else begin
         if (forca_ocioso) begin
            us_habilitado <= 1'b0;
         end else if (sensor_livre) begin
            us_habilitado <= 1'b1;
         end

         if (estado_prox == ESPERA && estado != ESPERA) begin
            cnt_periodo <= W_PER'(PERIODO_MEDIDA);
         end else if (estado == ESPERA && cnt_periodo != '0) begin
            cnt_periodo <= cnt_periodo - W_PER'(1);
         end

         if (pulso_medir) begin
            cnt_timeout <= W_TO'(TIMEOUT_CICLOS);
         end else if (estado == MEDE && cnt_timeout != '0) begin
            cnt_timeout <= cnt_timeout - W_TO'(1);
         end

         if (estado == MEDE && estado_prox == CONVERTE) begin
            acumulador <= {1'b0, distancia_cm} + MEIA;
            quociente  <= '0;
         end else if (estado == CONVERTE && estado_prox == CONVERTE) begin
            acumulador <= acumulador - ALTURA;
            quociente  <= quociente + W_Q'(1);
         end
      end
   end

   // Published floor value and flags; sensor acceptance overrides any ultrasonic result
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         andar        <= '0;
         andar_valido <= 1'b0;
         fonte        <= FONTE_SENSOR;
         mudou        <= 1'b0;
         medir        <= 1'b0;
         erro_sensor  <= 1'b0;
         erro_us      <= 1'b0;
      end else begin
         mudou <= 1'b0;
         medir <= pulso_medir;
         if (sensor_unico) begin
            andar        <= idx_baixo;
            fonte        <= FONTE_SENSOR;
            andar_valido <= 1'b1;
            erro_sensor  <= 1'b0;
            erro_us      <= 1'b0;
            mudou        <= !andar_valido || (idx_baixo != andar);
         end else if (sensor_multiplo) begin
            erro_sensor <= 1'b1;
         end else begin
            if (sensor_livre) erro_sensor <= 1'b0;
            if (ev_conv_ok) begin
               andar        <= quociente[W_ANDAR-1:0];
               fonte        <= FONTE_US;
               andar_valido <= 1'b1;
               erro_us      <= 1'b0;
               mudou        <= !andar_valido || (quociente[W_ANDAR-1:0] != andar);
            end else if (ev_timeout || ev_conv_fora) begin
               erro_us <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_andar_fusao.sv
// Directed self-checking bench for andar_fusao with a small expectation queue.
module tb_andar_fusao;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int PER = 16;
   localparam int TO  = 20;
   localparam int ALT = 10;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  sensores;
   logic [11:0] distancia_cm;
   logic        distancia_valida;
   logic        medir;
   logic [1:0]  andar;
   logic        andar_valido;
   logic        fonte;
   logic        mudou;
   logic        erro_sensor;
   logic        erro_us;

   int n_checks  = 0;
   int n_pass    = 0;
   int n_fail    = 0;
   int mudou_cnt = 0;
   int medir_cnt = 0;

   typedef struct {
      string      tag;
      logic [1:0] andar;
      logic       fonte;
      logic       valido;
      int         mudou_n;
   } exp_t;

   exp_t sb[$];

   andar_fusao #(
      .N_ANDARES       (N),
      .W_ANDAR         (2),
      .DEBOUNCE_CICLOS (DEB),
      .PERIODO_MEDIDA  (PER),
      .TIMEOUT_CICLOS  (TO),
      .ALTURA_CM       (ALT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .sensores         (sensores),
      .distancia_cm     (distancia_cm),
      .distancia_valida (distancia_valida),
      .medir            (medir),
      .andar            (andar),
      .andar_valido     (andar_valido),
      .fonte            (fonte),
      .mudou            (mudou),
      .erro_sensor      (erro_sensor),
      .erro_us          (erro_us)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   // Safety net in case some wait escapes its bound
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time 100000 reached, required finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         if (mudou === 1'b1) mudou_cnt++;
         if (medir === 1'b1) medir_cnt++;
      end
   endtask

   task automatic wait_medir(input string tag, input int budget, output int ciclos);
      ciclos = 0;
      do begin
         tick(1);
         ciclos++;
      end while (medir !== 1'b1 && ciclos < budget);
      check_output({tag, "_medir_seen"}, 32'(medir), 32'd1);
   endtask

   task automatic wait_mudou(input string tag, input int budget, output int ciclos);
      ciclos = 0;
      do begin
         tick(1);
         ciclos++;
      end while (mudou !== 1'b1 && ciclos < budget);
      check_output({tag, "_mudou_seen"}, 32'(mudou), 32'd1);
   endtask

   task automatic apply_stimulus(input logic [11:0] d);
      distancia_cm     = d;
      distancia_valida = 1'b1;
      tick(1);
      distancia_valida = 1'b0;
   endtask

   task automatic push_exp(input string tag, input logic [1:0] a, input logic f,
                           input logic v, input int m);
      exp_t e;
      e.tag     = tag;
      e.andar   = a;
      e.fonte   = f;
      e.valido  = v;
      e.mudou_n = m;
      sb.push_back(e);
   endtask

   task automatic compare_sb(input int mudou_obs);
      exp_t e;
      e = sb.pop_front();
      check_output({e.tag, "_andar"},  32'(andar),        32'(e.andar));
      check_output({e.tag, "_fonte"},  32'(fonte),        32'(e.fonte));
      check_output({e.tag, "_valido"}, 32'(andar_valido), 32'(e.valido));
      check_output({e.tag, "_mudou"},  32'(mudou_obs),    32'(e.mudou_n));
   endtask

   // Directed scenario sequence
   initial begin
      int c;
      int m0;
      int md0;

      reset            = 1'b1;
      sensores         = 4'b1011;
      distancia_cm     = '0;
      distancia_valida = 1'b0;
      tick(3);
      check_output("reset_outputs",
                   32'({andar, andar_valido, fonte, mudou, medir, erro_sensor, erro_us}), 32'd0);

      // Scenario 1: single sensor at floor 2, then a short glitch
      $display("[TB] scenario 1: sensor floor 2");
      reset = 1'b0;
      m0 = mudou_cnt;
      push_exp("s1_sensor", 2'd2, 1'b0, 1'b1, 1);
      wait_mudou("s1", 20, c);
      check_output("s1_latency", 32'(c), 32'(2 + DEB + 1));
      tick(4);
      compare_sb(mudou_cnt - m0);
      sensores = 4'b1111;
      tick(2);
      sensores = 4'b1011;
      m0  = mudou_cnt;
      md0 = medir_cnt;
      tick(12);
      check_output("s1_glitch_andar", 32'(andar), 32'd2);
      check_output("s1_glitch_mudou", 32'(mudou_cnt - m0), 32'd0);
      check_output("s1_glitch_medir", 32'(medir_cnt - md0), 32'd0);

      // Scenario 2: ultrasonic reply 24 cm -> floor 2 from ultrasonic, no change pulse
      $display("[TB] scenario 2: ultrasonic 24 cm");
      sensores = 4'b1111;
      md0 = medir_cnt;
      wait_medir("s2", 60, c);
      apply_stimulus(12'd24);
      check_output("s2_medir_width", 32'(medir), 32'd0);
      m0 = mudou_cnt;
      push_exp("s2_us", 2'd2, 1'b1, 1'b1, 0);
      tick(N + 2);
      compare_sb(mudou_cnt - m0);
      check_output("s2_medir_count", 32'(medir_cnt - md0), 32'd1);

      // Scenario 3: out-of-range reply, then a valid short reply
      $display("[TB] scenario 3: ultrasonic range");
      wait_medir("s3a", 40, c);
      apply_stimulus(12'd45);
      m0 = mudou_cnt;
      push_exp("s3_far", 2'd2, 1'b1, 1'b1, 0);
      tick(N + 2);
      compare_sb(mudou_cnt - m0);
      check_output("s3_far_erro_us", 32'(erro_us), 32'd1);
      wait_medir("s3b", 40, c);
      apply_stimulus(12'd5);
      m0 = mudou_cnt;
      push_exp("s3_near", 2'd1, 1'b1, 1'b1, 1);
      tick(N + 2);
      compare_sb(mudou_cnt - m0);
      check_output("s3_near_erro_us", 32'(erro_us), 32'd0);

      // Scenario 4: no reply -> timeout, then a fresh request after one period
      $display("[TB] scenario 4: ultrasonic timeout");
      wait_medir("s4a", 40, c);
      c = 0;
      do begin
         tick(1);
         c++;
      end while (erro_us !== 1'b1 && c < 40);
      check_output("s4_timeout_cycles", 32'(c), 32'(TO));
      check_output("s4_andar_hold", 32'(andar), 32'd1);
      wait_medir("s4b", 40, c);
      check_output("s4_period_cycles", 32'(c), 32'(PER));

      // Scenario 5: two sensors low, late reply ignored, then floor 3 from sensor
      $display("[TB] scenario 5: sensor error then floor 3");
      sensores = 4'b1001;
      tick(12);
      check_output("s5_erro_sensor", 32'(erro_sensor), 32'd1);
      check_output("s5_andar_hold", 32'(andar), 32'd1);
      check_output("s5_erro_us_hold", 32'(erro_us), 32'd1);
      m0 = mudou_cnt;
      apply_stimulus(12'd24);
      tick(N + 2);
      check_output("s5_late_reply_andar", 32'(andar), 32'd1);
      check_output("s5_late_reply_mudou", 32'(mudou_cnt - m0), 32'd0);
      md0 = medir_cnt;
      tick(40);
      check_output("s5_no_medir", 32'(medir_cnt - md0), 32'd0);
      sensores = 4'b0111;
      m0 = mudou_cnt;
      push_exp("s5_sensor", 2'd3, 1'b0, 1'b1, 1);
      wait_mudou("s5", 20, c);
      check_output("s5_latency", 32'(c), 32'(2 + DEB + 1));
      tick(2);
      compare_sb(mudou_cnt - m0);
      check_output("s5_erro_sensor_clr", 32'(erro_sensor), 32'd0);
      check_output("s5_erro_us_clr", 32'(erro_us), 32'd0);

      // Scenario 6: reset in the middle of a conversion
      $display("[TB] scenario 6: reset during conversion");
      sensores = 4'b1111;
      wait_medir("s6a", 60, c);
      apply_stimulus(12'd25);
      #2;
      reset = 1'b1;
      #1;
      check_output("s6_async_reset",
                   32'({andar, andar_valido, fonte, mudou, medir, erro_sensor, erro_us}), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(3);
      apply_stimulus(12'd24);
      tick(8);
      check_output("s6_ignored_andar", 32'(andar), 32'd0);
      check_output("s6_ignored_valido", 32'(andar_valido), 32'd0);
      wait_medir("s6b", 60, c);
      apply_stimulus(12'd15);
      m0 = mudou_cnt;
      push_exp("s6_first", 2'd2, 1'b1, 1'b1, 1);
      tick(N + 2);
      compare_sb(mudou_cnt - m0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
